// File: rtl/bcd_load_chain_pkg.sv
// bcd_load_chain_pkg
//   Shared types and helpers for the BCD load chain: the digit type,
//   the decade limit, the load-handshake FSM state encoding and a
//   digit-validity check.
package bcd_load_chain_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    LC_IDLE    = 2'd0,
    LC_CAPTURE = 2'd1,
    LC_ACK     = 2'd2,
    LC_DROP    = 2'd3
  } lc_state_e;

  function automatic logic is_bcd(bcd_t d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_load_chain_digit.sv
// bcd_digit
//   One decade stage of the chain. Loads d_i when ld_i, otherwise
//   increments when ci_i, wrapping 9 -> 0.
//   Ports:
//     clk_i  clock, posedge
//     rst_i  synchronous active-high reset (q_o -> 0)
//     ci_i   carry in / increment request
//     ld_i   parallel load strobe
//     d_i    load value (caller guarantees it is a valid BCD digit)
//     q_o    digit value
//     co_o   carry out: ci_i && q_o == 9
module bcd_digit
  import bcd_load_chain_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ci_i,
  input  logic       ld_i,
  input  logic [3:0] d_i,
  output logic [3:0] q_o,
  output logic       co_o
);

  bcd_t q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (ld_i)      q_d = d_i;
    else if (ci_i) q_d = (q_q == BCD_MAX) ? 4'd0 : q_q + 4'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q_o  = q_q;
  assign co_o = ci_i && (q_q == BCD_MAX);

endmodule

// File: rtl/bcd_load_chain.sv
// bcd_load_chain
//   DIGITS-wide BCD counter with a ripple-carry decade chain and a
//   four-phase load handshake (IDLE -> CAPTURE -> ACK -> [DROP] -> IDLE).
//   A load request in IDLE is latched into a shadow register; the next
//   cycle either copies it into the counter (all digits valid) or flags
//   an error and leaves the counter alone. ACK is a one-cycle Moore pulse.
//   Ports:
//     clk_i       clock, posedge
//     rst_i       synchronous active-high reset
//     en_i        count enable (accepted in IDLE without a load, and in DROP)
//     load_req_i  four-phase load request
//     load_val_i  packed BCD load value, digit 0 in [3:0]
//     load_ack_o  one-cycle load acknowledge
//     load_err_o  coincident with load_ack_o when the value had a non-BCD digit
//     q_o         packed BCD counter value
//     tc_o        terminal count: accepted enable with every digit at 9
//   Optional: define BCD_LOAD_CHAIN_ASSERT_EN to compile in protocol and
//   range assertions.
module bcd_load_chain
  import bcd_load_chain_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                load_req_i,
  input  logic [4*DIGITS-1:0] load_val_i,
  output logic                load_ack_o,
  output logic                load_err_o,
  output logic [4*DIGITS-1:0] q_o,
  output logic                tc_o
);

  lc_state_e           state_q, state_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic                err_q, err_d;
  logic [DIGITS-1:0]   dig_ok;
  logic [DIGITS:0]     carry;
  logic                shadow_ok, count_en, ld;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= LC_IDLE;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LC_IDLE:    if (load_req_i) state_d = LC_CAPTURE;
      LC_CAPTURE: state_d = LC_ACK;
      LC_ACK:     state_d = load_req_i ? LC_DROP : LC_IDLE;
      LC_DROP:    if (!load_req_i) state_d = LC_IDLE;
      default:    state_d = LC_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    load_ack_o = (state_q == LC_ACK);
    load_err_o = (state_q == LC_ACK) && err_q;
    // A load request in IDLE takes priority, so that cycle's enable is dropped.
    count_en   = en_i && (((state_q == LC_IDLE) && !load_req_i) ||
                          (state_q == LC_DROP));
    ld         = (state_q == LC_CAPTURE) && shadow_ok;
  end

  // ---------------- shadow register and error flag ----------------
  always_comb begin
    shadow_d = shadow_q;
    err_d    = err_q;
    if ((state_q == LC_IDLE) && load_req_i) shadow_d = load_val_i;
    if (state_q == LC_CAPTURE)              err_d    = !shadow_ok;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q <= '0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      err_q    <= err_d;
    end
  end

  // ---------------- decade chain ----------------
  assign carry[0] = count_en;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    assign dig_ok[i] = is_bcd(shadow_q[4*i +: 4]);

    bcd_digit u_dig (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .ci_i  (carry[i]),
      .ld_i  (ld),
      .d_i   (shadow_q[4*i +: 4]),
      .q_o   (q_o[4*i +: 4]),
      .co_o  (carry[i+1])
    );
  end

  assign shadow_ok = &dig_ok;
  // The final carry is exactly "accepted enable and all digits are 9".
  assign tc_o      = carry[DIGITS];

`ifdef BCD_LOAD_CHAIN_ASSERT_EN
  logic [DIGITS-1:0] q_ok;
  for (genvar i = 0; i < DIGITS; i++) begin : g_qok
    assign q_ok[i] = is_bcd(q_o[4*i +: 4]);
  end

  a_req_ack: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == LC_IDLE && load_req_i) |-> ##2 load_ack_o)
    else $error("a_req_ack: load_ack not seen 2 cycles after accepted load_req");

  a_ack_pulse: assert property (@(posedge clk_i) disable iff (rst_i)
    load_ack_o |=> !load_ack_o)
    else $error("a_ack_pulse: load_ack high for more than one cycle");

  a_load_val: assert property (@(posedge clk_i) disable iff (rst_i)
    (load_ack_o && !load_err_o) |-> (q_o == $past(load_val_i, 2)))
    else $error("a_load_val: q does not match the acknowledged load value");

  a_q_bcd: assert property (@(posedge clk_i) disable iff (rst_i)
    &q_ok)
    else $error("a_q_bcd: non-BCD digit on q");

  a_tc_wrap: assert property (@(posedge clk_i) disable iff (rst_i)
    tc_o |=> (q_o == '0))
    else $error("a_tc_wrap: q not zero after terminal count");
`endif

endmodule

// File: tb/tb_bcd_load_chain.sv
module tb_bcd_load_chain;

  logic        clk = 1'b0;
  logic        rst, en, load_req;
  logic [15:0] load_val;
  logic        load_ack, load_err, tc;
  logic [15:0] q;
  int          n_vec = 0;
  int          n_err = 0;

  bcd_load_chain #(.DIGITS(4)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .load_req_i (load_req),
    .load_val_i (load_val),
    .load_ack_o (load_ack),
    .load_err_o (load_err),
    .q_o        (q),
    .tc_o       (tc)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle away from it.
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chkq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; load_req = 1'b0; load_val = 16'h0000;
    tick(2);
    chkq("rst_q", q, 16'h0000);
    chk1("rst_ack", load_ack, 1'b0);
    chk1("rst_err", load_err, 1'b0);
    chk1("rst_tc", tc, 1'b0);

    // Counting from zero
    rst = 1'b0;
    tick(10);
    chkq("cnt10", q, 16'h0010);
    chk1("cnt10_tc", tc, 1'b0);
    tick(90);
    chkq("cnt100", q, 16'h0100);
    en = 1'b0;

    // Load 0999, drop request before T+2 (ACK -> IDLE)
    load_req = 1'b1; load_val = 16'h0999;
    tick();                                  // edge T: IDLE -> CAPTURE
    chk1("ld0999_ack_T", load_ack, 1'b0);
    chkq("ld0999_q_T", q, 16'h0100);
    tick();                                  // edge T+1: q loaded, ACK
    chkq("ld0999_q", q, 16'h0999);
    chk1("ld0999_ack", load_ack, 1'b1);
    chk1("ld0999_err", load_err, 1'b0);
    load_req = 1'b0;
    tick();                                  // edge T+2: back to IDLE
    chk1("ld0999_ack_off", load_ack, 1'b0);
    en = 1'b1; #1;
    chk1("ld0999_tc", tc, 1'b0);
    tick();
    chkq("inc_to_1000", q, 16'h1000);
    en = 1'b0;

    // Load 9999, hold request through ACK, wrap while in DROP
    load_req = 1'b1; load_val = 16'h9999;
    tick(2);
    chkq("ld9999_q", q, 16'h9999);
    chk1("ld9999_ack", load_ack, 1'b1);
    en = 1'b1; #1;
    chk1("ack_tc_forced0", tc, 1'b0);
    tick();                                  // ACK -> DROP, en ignored in ACK
    chkq("ack_en_ignored", q, 16'h9999);
    chk1("drop_ack_off", load_ack, 1'b0);
    chk1("drop_tc", tc, 1'b1);
    tick();
    chkq("wrap_q", q, 16'h0000);
    chk1("wrap_tc", tc, 1'b0);
    en = 1'b0; load_req = 1'b0;
    tick();                                  // DROP -> IDLE

    // Non-BCD load value
    load_req = 1'b1; load_val = 16'h12A4;
    tick(2);
    chk1("bad_ack", load_ack, 1'b1);
    chk1("bad_err", load_err, 1'b1);
    chkq("bad_q_held", q, 16'h0000);
    load_req = 1'b0;
    tick();
    chk1("bad_ack_off", load_ack, 1'b0);
    chk1("bad_err_off", load_err, 1'b0);

    // Good load after an error clears the error flag
    load_req = 1'b1; load_val = 16'h0042;
    tick(2);
    chkq("ld0042_q", q, 16'h0042);
    chk1("ld0042_err", load_err, 1'b0);
    load_req = 1'b0;
    tick();

    // Reset during CAPTURE abandons the load
    load_req = 1'b1; load_val = 16'h0777;
    tick();                                  // now in CAPTURE
    rst = 1'b1; load_req = 1'b0;
    tick();
    chkq("rstcap_q", q, 16'h0000);
    chk1("rstcap_ack", load_ack, 1'b0);
    rst = 1'b0;
    tick();
    chk1("rstcap_ack2", load_ack, 1'b0);
    chkq("rstcap_q2", q, 16'h0000);

    // en high throughout a load: count lost at T, ignored in CAPTURE/ACK
    en = 1'b1; load_req = 1'b1; load_val = 16'h0042;
    tick();                                  // T: load wins over en
    chkq("en_lost_T", q, 16'h0000);
    chk1("cap_tc", tc, 1'b0);
    load_req = 1'b0;
    tick();                                  // CAPTURE: load, en ignored
    chkq("en_cap_q", q, 16'h0042);
    tick();                                  // ACK: en ignored -> IDLE
    chkq("en_ack_q", q, 16'h0042);
    tick();                                  // IDLE: count resumes
    chkq("en_resume_q", q, 16'h0043);
    en = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
